// File: rtl/apb_uart_fifo.sv
`timescale 1ns/1ps

// Generic pointer FIFO with an extra wrap bit per pointer.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: a push while full is accepted only with a same-cycle pop; a pop while empty is refused.
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         pop_ok;
    logic         push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = LW'(wr_ptr - rd_ptr);
    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// APB3 UART with TX/RX FIFOs, programmable baud, optional parity, 1/2 stop bits, sticky interrupts.
// Latency: zero-wait-state APB; serial bytes leave one cycle after the TX FSM pops them.
// Backpressure: TXDATA write while TX full errors and drops; RX byte arriving while RX full is dropped (overrun).
module apb_uart_fifo #(
    parameter int ADDR_W   = 12,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int DIV_W    = 16
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic              rx_i,
    output logic              tx_o,
    output logic              intr_o
);
    localparam int TX_LW = $clog2(TX_DEPTH) + 1;
    localparam int RX_LW = $clog2(RX_DEPTH) + 1;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_BAUD   = 3'd1;
    localparam logic [2:0] OFF_TXDATA = 3'd2;
    localparam logic [2:0] OFF_RXDATA = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
    localparam logic [2:0] OFF_IE     = 3'd5;
    localparam logic [2:0] OFF_IP     = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} ser_state_t;

    logic [4:0]       ctrl;
    logic [DIV_W-1:0] baud;
    logic [4:0]       ie;
    logic [4:0]       ip;
    logic [4:0]       ip_next;
    logic [4:0]       ip_set;
    logic [4:0]       ip_clr;

    logic       tx_en, rx_en, par_en, par_odd, two_stop;
    logic [2:0] dec_off;
    logic       dec_map;
    logic       access, wr_acc, rd_acc;

    logic             tx_push, tx_pop, tx_full, tx_empty, tx_empty_ev;
    logic [7:0]       tx_head;
    logic [TX_LW-1:0] tx_level;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_head;
    logic [RX_LW-1:0] rx_level;

    logic unused_ok;
    assign unused_ok = ^{paddr_i[1:0], pwdata_i};

    assign tx_en    = ctrl[0];
    assign rx_en    = ctrl[1];
    assign par_en   = (ctrl[3:2] == 2'b01) || (ctrl[3:2] == 2'b10);
    assign par_odd  = (ctrl[3:2] == 2'b10);
    assign two_stop = ctrl[4];

    // Address decode is captured in the setup phase and used in the following access phase.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            dec_off <= '0;
            dec_map <= 1'b0;
        end else if (psel_i && !penable_i) begin
            dec_off <= paddr_i[4:2];
            dec_map <= ~(|paddr_i[ADDR_W-1:5]) & (paddr_i[4:2] != 3'd7);
        end
    end

    assign access    = psel_i & penable_i;
    assign wr_acc    = access & pwrite_i & dec_map;
    assign rd_acc    = access & ~pwrite_i & dec_map;
    assign tx_push   = wr_acc & (dec_off == OFF_TXDATA) & ~tx_full;
    assign rx_pop    = rd_acc & (dec_off == OFF_RXDATA);
    assign pready_o  = access;
    assign pslverr_o = access & (~dec_map | (pwrite_i & (dec_off == OFF_TXDATA) & tx_full));

    always_comb begin
        prdata_o = '0;
        if (rd_acc) begin
            case (dec_off)
                OFF_CTRL:   prdata_o = {27'b0, ctrl};
                OFF_BAUD:   prdata_o = 32'(baud);
                OFF_RXDATA: prdata_o = {24'b0, rx_empty ? 8'h00 : rx_head};
                OFF_STATUS: begin
                    prdata_o[0]     = tx_full;
                    prdata_o[1]     = tx_empty;
                    prdata_o[2]     = rx_full;
                    prdata_o[3]     = rx_empty;
                    prdata_o[4]     = tx_busy;
                    prdata_o[15:8]  = 8'(tx_level);
                    prdata_o[23:16] = 8'(rx_level);
                end
                OFF_IE:     prdata_o = {27'b0, ie};
                OFF_IP:     prdata_o = {27'b0, ip};
                default:    prdata_o = '0;
            endcase
        end
    end

    // Events are OR'd in after the W1C mask so a same-cycle set always survives.
    assign ip_clr  = (wr_acc && dec_off == OFF_IP) ? pwdata_i[4:0] : 5'b0;
    assign ip_next = (ip & ~ip_clr) | ip_set;
    assign intr_o  = |(ip & ie);

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            ctrl <= '0;
            baud <= DIV_W'(16);
            ie   <= '0;
            ip   <= '0;
        end else begin
            if (wr_acc) begin
                case (dec_off)
                    OFF_CTRL: ctrl <= pwdata_i[4:0];
                    OFF_BAUD: baud <= (pwdata_i[DIV_W-1:0] < DIV_W'(4)) ? DIV_W'(4) : pwdata_i[DIV_W-1:0];
                    OFF_IE:   ie   <= pwdata_i[4:0];
                    default:  ;
                endcase
            end
            ip <= ip_next;
        end
    end

    uart_fifo #(.W(8), .DEPTH(TX_DEPTH), .LW(TX_LW)) u_tx_fifo (
        .clk(pclk_i), .rst(prst_i), .push(tx_push), .push_dat(pwdata_i[7:0]), .pop(tx_pop),
        .pop_dat(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    // ---------------- TX serialiser ----------------
    ser_state_t       tx_state, tx_state_d;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic [7:0]       tx_data, tx_data_d;
    logic             tx_stop2, tx_stop2_d;
    logic             tx_line;
    logic             tx_busy;

    assign tx_busy     = (tx_state != S_IDLE);
    assign tx_empty_ev = tx_pop & (tx_level == TX_LW'(1)) & ~tx_push;

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_data  <= '0;
            tx_stop2 <= 1'b0;
            tx_o     <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_data  <= tx_data_d;
            tx_stop2 <= tx_stop2_d;
            tx_o     <= tx_line;
        end
    end

    // The bit counter reloads from the live BAUD register at every bit boundary.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_data_d  = tx_data;
        tx_stop2_d = tx_stop2;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        if (tx_state != S_IDLE) tx_cnt_d = tx_cnt - 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (tx_en && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_head;
                    tx_cnt_d   = baud - 1'b1;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_cnt == '0) begin
                    tx_cnt_d   = baud - 1'b1;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_line = tx_data[tx_bit];
                if (tx_cnt == '0) begin
                    tx_cnt_d = baud - 1'b1;
                    tx_bit_d = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = par_en ? S_PARITY : S_STOP;
                        tx_stop2_d = two_stop;
                    end
                end
            end
            S_PARITY: begin
                tx_line = (^tx_data) ^ par_odd;
                if (tx_cnt == '0) begin
                    tx_cnt_d   = baud - 1'b1;
                    tx_state_d = S_STOP;
                    tx_stop2_d = two_stop;
                end
            end
            S_STOP: begin
                if (tx_cnt == '0) begin
                    tx_cnt_d = baud - 1'b1;
                    if (tx_stop2) tx_stop2_d = 1'b0;
                    else          tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // ---------------- RX deserialiser ----------------
    ser_state_t       rx_state, rx_state_d;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]       rx_bit, rx_bit_d;
    logic [7:0]       rx_data, rx_data_d;
    logic             rx_par_bad, rx_par_bad_d;
    logic             rx_meta, rx_s, rx_prev;
    logic             rx_overrun, rx_par_err, rx_frame_err;

    uart_fifo #(.W(8), .DEPTH(RX_DEPTH), .LW(RX_LW)) u_rx_fifo (
        .clk(pclk_i), .rst(prst_i), .push(rx_push), .push_dat(rx_data), .pop(rx_pop),
        .pop_dat(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    assign ip_set = {rx_frame_err, rx_par_err, rx_overrun, rx_push, tx_empty_ev};

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_data    <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            rx_meta    <= rx_i;
            rx_s       <= rx_meta;
            rx_prev    <= rx_s;
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_bit     <= rx_bit_d;
            rx_data    <= rx_data_d;
            rx_par_bad <= rx_par_bad_d;
        end
    end

    // Half a bit after the falling edge confirms the start bit; later samples land mid-bit.
    always_comb begin
        rx_state_d   = rx_state;
        rx_cnt_d     = rx_cnt;
        rx_bit_d     = rx_bit;
        rx_data_d    = rx_data;
        rx_par_bad_d = rx_par_bad;
        rx_push      = 1'b0;
        rx_overrun   = 1'b0;
        rx_par_err   = 1'b0;
        rx_frame_err = 1'b0;
        if (rx_state != S_IDLE) rx_cnt_d = rx_cnt - 1'b1;
        if (!rx_en) begin
            rx_state_d = S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_cnt_d   = (baud >> 1) - 1'b1;
                        rx_state_d = S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_s) begin
                            rx_state_d = S_IDLE;
                        end else begin
                            rx_cnt_d     = baud - 1'b1;
                            rx_bit_d     = 3'd0;
                            rx_par_bad_d = 1'b0;
                            rx_state_d   = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt_d          = baud - 1'b1;
                        rx_data_d[rx_bit] = rx_s;
                        rx_bit_d          = rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state_d = par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == '0) begin
                        rx_cnt_d     = baud - 1'b1;
                        rx_par_bad_d = (rx_s != ((^rx_data) ^ par_odd));
                        rx_state_d   = S_STOP;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state_d = S_IDLE;
                        if (!rx_s)           rx_frame_err = 1'b1;
                        else if (rx_par_bad) rx_par_err   = 1'b1;
                        else if (rx_full)    rx_overrun   = 1'b1;
                        else                 rx_push      = 1'b1;
                    end
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
    end
endmodule
